// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the width defaults, the FSM state encoding and the decimal
// limit used for the overflow compare.
package bcd_pkg;

  localparam int BIN_W_DEF  = 27;
  localparam int DIGITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // 10^n as a 64-bit constant; used to build the overflow threshold
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Largest value that still fits in DIGITS_DEF decimal digits, plus one
  localparam longint unsigned MAX_DEC = pow10(DIGITS_DEF);

endpackage

// File: rtl/bcd_add3.sv
// One-digit double-dabble corrector: a BCD digit of 5 or more gets 3
// added so that the following left shift carries correctly into the
// next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Add 3 when the digit would become 10 or more after doubling
  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Handshake: start is sampled only in IDLE or DONE; bin_in is captured on
// that accepting edge. busy is high for the BIN_W conversion edges, then
// done pulses for one cycle while digits/overflow carry the new result.
// digits/overflow only change on the edge that raises done.
// Optional build macro: BCD_SAT_EN -- when defined, an overflowing input
// shows all 9s on digits instead of the raw value mod 10^DIGITS.
module bin_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);

  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam int BCD_W  = 4 * DIGITS;
  localparam longint unsigned MAX_DEC_P = pow10(DIGITS);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                ovf_q, ovf_d;
  logic [BCD_W-1:0]    digits_q, digits_d;
  logic                overflow_q, overflow_d;

  logic [BCD_W-1:0]       bcd_corr;
  logic [BCD_W+BIN_W-1:0] shift_w;
  logic                   accept;

  // Per-digit add-3 correction of the current accumulator
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_q[4*g +: 4]),
      .q (bcd_corr[4*g +: 4])
    );
  end

  // Next-state, datapath update and result load
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    accept     = 1'b0;
    // Top bits pushed out of the last digit are simply dropped
    shift_w    = {bcd_corr, bin_q} << 1;

    case (state_q)
      IDLE: begin
        accept = start;
      end
      CONV: begin
        bcd_d  = shift_w[BCD_W+BIN_W-1 -: BCD_W];
        bin_d  = shift_w[BIN_W-1:0];
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BIN_W - 1)) begin
          state_d    = DONE;
          overflow_d = ovf_q;
`ifdef BCD_SAT_EN
          digits_d   = ovf_q ? ALL_NINES : shift_w[BCD_W+BIN_W-1 -: BCD_W];
`else
          digits_d   = shift_w[BCD_W+BIN_W-1 -: BCD_W];
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accepting a request (from IDLE or back-to-back from DONE)
    if (accept) begin
      state_d = CONV;
      bin_d   = bin_in;
      bcd_d   = '0;
      iter_d  = '0;
      ovf_d   = (64'(bin_in) >= MAX_DEC_P);
    end
  end

  // State and datapath registers; reset abandons any conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs are decoded straight from registers only
  assign busy     = (state_q == CONV);
  assign done     = (state_q == DONE);
  assign digits   = ALL_NINES_UNUSED_GUARD(digits_q);
  assign overflow = overflow_q;

  function automatic logic [BCD_W-1:0] ALL_NINES_UNUSED_GUARD(input logic [BCD_W-1:0] v);
    // Pass-through; keeps ALL_NINES referenced in builds without saturation
    return v | (ALL_NINES & '0);
  endfunction

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq. Expected {overflow, digits} words and
// accept-cycle stamps are queued when a conversion is accepted and popped
// when done is seen. Honours BCD_SAT_EN for the overflow expectation.
module tb_bin_bcd_seq;
  import bcd_pkg::*;

  localparam int W = 4 * DIGITS_DEF + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [26:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] digits;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  bin_bcd_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .overflow (overflow)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by repeated division
  function automatic logic [31:0] model_digits(input longint unsigned v);
    logic [31:0] r;
    longint unsigned m;
    r = '0;
    m = v % 64'd100000000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
`ifdef BCD_SAT_EN
    if (v >= 64'd100000000) r = 32'h99999999;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compare every done against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("busy_with_done", 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [W-1:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("digits", 64'(digits), 64'(e[31:0]));
          check("overflow", 64'(overflow), 64'(e[32]));
          check("latency", 64'(cyc - a), 64'd27);
        end
      end
    end
  end

  // Drive one request from idle and queue its expected result
  task automatic start_conv(input logic [26:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({(64'(v) >= 64'd100000000), model_digits(64'(v))});
    acc_q.push_back(cyc);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    logic [26:0] rv;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_digits", 64'(digits), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic conversion and busy length
    busy_cnt = 0;
    start_conv(27'd4652);
    wait_idle(60);
    check("busy_cycles", 64'(busy_cnt), 64'd27);

    // Zero, upper limit, overflow
    start_conv(27'd0);
    wait_idle(60);
    start_conv(27'd99_999_999);
    wait_idle(60);
    start_conv(27'd134_217_727);
    wait_idle(60);

    // A few random values
    for (int i = 0; i < 4; i++) begin
      rv = 27'($urandom_range(0, 134217727));
      start_conv(rv);
      wait_idle(60);
    end

    // Handshake: ignored start mid-conversion, then back-to-back from DONE
    start_conv(27'd134_217_727);
    wait_idle(60);
    dc = done_cnt;
    start_conv(27'd1234);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    bin_in = 27'd5678;
    check("hold_mid_conv_digits", 64'(digits), 64'(model_digits(64'd134217727)));
    check("hold_mid_conv_ovf", 64'(overflow), 64'd1);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(60);
    start  = 1'b1;
    bin_in = 27'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({1'b0, model_digits(64'd5678)});
    acc_q.push_back(cyc);
    wait_idle(60);
    repeat (3) @(negedge clk);
    check("handshake_done_count", 64'(done_cnt - dc), 64'd2);

    // Reset in the middle of a conversion
    start_conv(27'd999);
    repeat (9) @(posedge clk);
    #2;
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_digits", 64'(digits), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 64'(done_cnt - dc), 64'd0);
    start_conv(27'd42);
    wait_idle(60);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
